// File: rtl/conv_pe_array_stage_if.sv
// rtl/conv_pe_array_stage_if.sv - Window-in / result-group-out stream bundle
// slave = the convolution stage, master = the window producer plus result consumer.
interface conv_pe_array_stage_if #(
  parameter int N                  = 3,
  parameter int BitSize            = 8,
  parameter int ProcessingElements = 2,
  parameter int GroupW             = 2
);
  logic                               in_valid;
  logic [N*N*BitSize-1:0]             in_data;
  logic                               in_ready;
  logic                               out_valid;
  logic                               out_ready;
  logic [ProcessingElements*BitSize-1:0] out_data;
  logic [GroupW-1:0]                  out_group;
  logic                               out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_group, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_group, out_last
  );
endinterface

// File: rtl/conv_pe_array_stage.sv
// rtl/conv_pe_array_stage.sv - Window FIFO feeding grouped kernel dot-products
// Each head window is emitted as Groups result beats, then popped on the last one.
module conv_pe_array_stage #(
  parameter int NumberOfK          = 8,
  parameter int N                  = 3,
  parameter int BitSize            = 8,
  parameter int KernelBitSize      = 1,
  parameter int ProcessingElements = 2,
  parameter int Depth              = 4,
  parameter int OutShift           = 0,
  parameter int Relu               = 0,
  parameter logic [KernelBitSize*N*N-1:0] kernel [NumberOfK-1:0] = '{default: '0}
) (
  input logic clk,
  input logic res_n,
  conv_pe_array_stage_if.slave bus
);
  localparam int Groups = NumberOfK / ProcessingElements;
  localparam int GroupW = (Groups > 1) ? $clog2(Groups) : 1;
  localparam int PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW   = $clog2(Depth + 1);
  localparam int KIdxW  = (NumberOfK > 1) ? $clog2(NumberOfK) : 1;
  localparam int SumW   = BitSize + KernelBitSize + $clog2(N * N);
  localparam int WinW   = N * N * BitSize;
  localparam logic signed [SumW-1:0] MaxV = SumW'((2 ** (BitSize - 1)) - 1);
  localparam logic signed [SumW-1:0] MinV = -MaxV - SumW'(1);

  logic [WinW-1:0]                       mem_q [Depth];
  logic [PtrW-1:0]                       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]                       count_q, count_d;
  logic [GroupW-1:0]                     g_q;
  logic                                  out_valid_q, out_last_q;
  logic [GroupW-1:0]                     out_group_q;
  logic [ProcessingElements*BitSize-1:0] out_data_q, lanes_d;
  logic                                  in_ready, push, load, is_last, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready = (count_q < CntW'(Depth)) && res_n;
  assign push     = bus.in_valid && in_ready;
  assign load     = (count_q != '0) && (!out_valid_q || bus.out_ready);
  assign is_last  = (g_q == GroupW'(Groups - 1));
  assign pop      = load && is_last;
  assign count_d  = count_q + CntW'(push) - CntW'(pop);

  // Lane p of group g uses kernel g*ProcessingElements+p against the FIFO head.
  always_comb begin
    logic [WinW-1:0]                  head;
    logic [KIdxW-1:0]                 kidx;
    logic [KernelBitSize*N*N-1:0]     kw_all;
    logic [KernelBitSize-1:0]         kw;
    logic signed [KernelBitSize:0]    w;
    logic signed [BitSize-1:0]        pix;
    logic signed [SumW-1:0]           sum, r;
    lanes_d = '0;
    head    = mem_q[rd_ptr_q];
    kidx    = '0;
    kw_all  = '0;
    kw      = '0;
    w       = '0;
    pix     = '0;
    sum     = '0;
    r       = '0;
    for (int p = 0; p < ProcessingElements; p++) begin
      kidx   = KIdxW'(int'(g_q) * ProcessingElements + p);
      kw_all = kernel[kidx];
      sum    = '0;
      for (int j = 0; j < N * N; j++) begin
        pix = head[j*BitSize +: BitSize];
        kw  = kw_all[j*KernelBitSize +: KernelBitSize];
        if (KernelBitSize == 1) w = kw[0] ? (KernelBitSize + 1)'(1) : '1;
        else                    w = {kw[KernelBitSize-1], kw};
        sum = sum + SumW'(pix) * SumW'(w);
      end
      r = sum >>> OutShift;
      if (Relu != 0 && r < 0) r = '0;
      if (r > MaxV)      r = MaxV;
      else if (r < MinV) r = MinV;
      lanes_d[p*BitSize +: BitSize] = r[BitSize-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      g_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_group_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= lanes_d;
        out_group_q <= g_q;
        out_last_q  <= is_last;
        if (is_last) begin
          g_q      <= '0;
          rd_ptr_q <= ptr_inc(rd_ptr_q);
        end else begin
          g_q <= g_q + 1'b1;
        end
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_group = out_group_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_conv_pe_array_stage.sv
// tb/tb_conv_pe_array_stage.sv - Directed bench for conv_pe_array_stage
// Four instances share one stimulus: base, ReLU, shift-by-2 and binary-weight variants.
module tb_conv_pe_array_stage;
  logic        clk = 1'b0;
  logic        res_n;
  logic        in_valid;
  logic [71:0] in_data;
  logic        out_ready;
  int          checks = 0;
  int          errors = 0;

  localparam logic [17:0] K2 [3:0] = '{{9{2'b01}}, 18'h00100, {9{2'b11}}, {9{2'b01}}};
  localparam logic [8:0]  K1 [3:0] = '{9'h000, 9'h1FF, 9'h000, 9'h1FF};

  always #5 clk = ~clk;

  conv_pe_array_stage_if #(.N(3), .BitSize(8), .ProcessingElements(2), .GroupW(1)) bus0 ();
  conv_pe_array_stage_if #(.N(3), .BitSize(8), .ProcessingElements(2), .GroupW(1)) bus1 ();
  conv_pe_array_stage_if #(.N(3), .BitSize(8), .ProcessingElements(2), .GroupW(1)) bus2 ();
  conv_pe_array_stage_if #(.N(3), .BitSize(8), .ProcessingElements(2), .GroupW(1)) bus3 ();

  assign bus0.in_valid = in_valid;  assign bus0.in_data = in_data;  assign bus0.out_ready = out_ready;
  assign bus1.in_valid = in_valid;  assign bus1.in_data = in_data;  assign bus1.out_ready = out_ready;
  assign bus2.in_valid = in_valid;  assign bus2.in_data = in_data;  assign bus2.out_ready = out_ready;
  assign bus3.in_valid = in_valid;  assign bus3.in_data = in_data;  assign bus3.out_ready = out_ready;

  conv_pe_array_stage #(.NumberOfK(4), .N(3), .BitSize(8), .KernelBitSize(2), .ProcessingElements(2),
    .Depth(4), .OutShift(0), .Relu(0), .kernel(K2)) dut (.clk(clk), .res_n(res_n), .bus(bus0));
  conv_pe_array_stage #(.NumberOfK(4), .N(3), .BitSize(8), .KernelBitSize(2), .ProcessingElements(2),
    .Depth(4), .OutShift(0), .Relu(1), .kernel(K2)) dut_relu (.clk(clk), .res_n(res_n), .bus(bus1));
  conv_pe_array_stage #(.NumberOfK(4), .N(3), .BitSize(8), .KernelBitSize(2), .ProcessingElements(2),
    .Depth(4), .OutShift(2), .Relu(0), .kernel(K2)) dut_shift (.clk(clk), .res_n(res_n), .bus(bus2));
  conv_pe_array_stage #(.NumberOfK(4), .N(3), .BitSize(8), .KernelBitSize(1), .ProcessingElements(2),
    .Depth(4), .OutShift(0), .Relu(0), .kernel(K1)) dut_bin (.clk(clk), .res_n(res_n), .bus(bus3));

  function automatic logic [71:0] win(input int v);
    logic [7:0] b;
    b = 8'(v);
    return {9{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_lanes(input string tag, input logic [15:0] d, input int e0, input int e1);
    chk({tag, ".lane0"}, $signed(d[7:0]), e0);
    chk({tag, ".lane1"}, $signed(d[15:8]), e1);
  endtask

  task automatic chk_main(input string tag, input int e0, input int e1, input int grp, input int last);
    chk({tag, ".valid"}, bus0.out_valid, 1);
    chk_lanes(tag, bus0.out_data, e0, e1);
    chk({tag, ".group"}, bus0.out_group, grp);
    chk({tag, ".last"}, bus0.out_last, last);
  endtask

  initial begin
    res_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst.valid", bus0.out_valid, 0);
    chk("rst.data", bus0.out_data, 0);
    chk("rst.group", bus0.out_group, 0);
    chk("rst.last", bus0.out_last, 0);
    chk("rst.in_ready", bus0.in_ready, 0);
    res_n = 1'b1; #1;
    chk("post_rst.in_ready", bus0.in_ready, 1);
    chk("post_rst.valid", bus0.out_valid, 0);

    // all-10 window: base, and shift-by-2 rounding toward minus infinity
    in_valid = 1'b1; in_data = win(10); tick();
    in_valid = 1'b0;
    chk("basic.latency", bus0.out_valid, 0);
    tick();
    chk_main("basic.g0", 90, -90, 0, 0);
    chk_lanes("shift.g0", bus2.out_data, 22, -23);
    tick();
    chk_main("basic.g1", 10, 90, 1, 1);
    chk_lanes("shift.g1", bus2.out_data, 2, 22);
    tick();
    chk("basic.drain", bus0.out_valid, 0);

    // all-100 window: saturation and ReLU
    in_valid = 1'b1; in_data = win(100); tick();
    in_valid = 1'b0; tick();
    chk_main("sat.g0", 127, -128, 0, 0);
    chk_lanes("relu.g0", bus1.out_data, 127, 0);
    tick();
    chk_main("sat.g1", 100, 127, 1, 1);
    chk_lanes("relu.g1", bus1.out_data, 100, 127);
    tick();

    // all-5 window: binary weights
    in_valid = 1'b1; in_data = win(5); tick();
    in_valid = 1'b0; tick();
    chk_lanes("bin.g0", bus3.out_data, 45, -45);
    chk("bin.g0.group", bus3.out_group, 0);
    tick();
    chk_lanes("bin.g1", bus3.out_data, 45, -45);
    chk("bin.g1.last", bus3.out_last, 1);
    tick();

    // backpressure: fill FIFO with windows 1..4, hold output for 5 cycles
    out_ready = 1'b0; in_valid = 1'b1; in_data = win(1); tick();
    chk("bp.acc1", bus0.in_ready, 1);
    in_data = win(2); tick();
    chk_main("bp.rise", 9, -9, 0, 0);
    in_data = win(3);
    for (int c = 0; c < 5; c++) begin
      tick();
      if (c == 0) in_data = win(4);
      else if (c == 1) in_data = win(5);
      chk_main("bp.hold", 9, -9, 0, 0);
      chk("bp.in_ready", bus0.in_ready, (c == 0) ? 1 : 0);
    end
    // final group of the full head leaves while window 5 is offered
    out_ready = 1'b1; tick();
    chk_main("full.pop", 1, 9, 1, 1);
    chk("full.in_ready_rise", bus0.in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_main("order", (i % 2) ? (2 + i / 2) : 9 * (2 + i / 2),
               (i % 2) ? 9 * (2 + i / 2) : -9 * (2 + i / 2), i % 2, i % 2);
      if (i == 0) begin
        chk("full.refill", bus0.in_ready, 0);
        in_valid = 1'b0;
      end
    end
    tick();
    chk("order.drain", bus0.out_valid, 0);

    // reset while group 0 of a window is being handed over
    in_valid = 1'b1; in_data = win(3); tick();
    in_valid = 1'b0; tick();
    chk_main("mid.g0", 27, -27, 0, 0);
    res_n = 1'b0; #1;
    chk("mid.rst_in_ready", bus0.in_ready, 0);
    tick();
    chk("mid.rst_valid", bus0.out_valid, 0);
    chk("mid.rst_data", bus0.out_data, 0);
    chk("mid.rst_in_ready2", bus0.in_ready, 0);
    res_n = 1'b1; #1;
    chk("mid.in_ready", bus0.in_ready, 1);
    chk("mid.valid", bus0.out_valid, 0);
    tick();
    chk("mid.no_stale1", bus0.out_valid, 0);
    tick();
    chk("mid.no_stale2", bus0.out_valid, 0);
    in_valid = 1'b1; in_data = win(4); tick();
    in_valid = 1'b0; tick();
    chk_main("mid.next_g0", 36, -36, 0, 0);
    tick();
    chk_main("mid.next_g1", 4, 36, 1, 1);
    tick();
    chk("mid.drain", bus0.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_pe_array_stage.md
# conv_pe_array_stage

Parameterised convolution stage that buffers incoming N×N pixel windows in a FIFO and evaluates them against a compile-time kernel bank. ProcessingElements dot-product units compute one group of kernels per cycle. Each result is shifted, optionally rectified, and saturated to BitSize. Results are delivered over a valid/ready handshake with group index and last-of-window flags. The block sits between the window generator and the pooling/dense stages, and supersedes the single-ready, no-backpressure convolution stage.

## Interface
- NumberOfK, 8, number of kernels; must be a multiple of ProcessingElements
- N, 3, kernel/window side length
- BitSize, 8, signed pixel and output width
- KernelBitSize, 1, kernel weight width; 1 = binary weights (bit 0 → −1, bit 1 → +1), >1 = signed two's complement
- ProcessingElements, 2, dot-product units evaluated in parallel
- Depth, 4, window FIFO depth (≥1)
- OutShift, 0, arithmetic right shift applied to each accumulated sum
- Relu, 0, 1 = clamp negative results to 0 before saturation
- kernel, all '0, unpacked array [NumberOfK-1:0] of [KernelBitSize*N*N-1:0]; weight j of kernel k is at [j*KernelBitSize +: KernelBitSize]
- Groups (derived), NumberOfK/ProcessingElements
- clk  in  1  clock, all state updates on rising edge
- res_n  in  1  synchronous active-low reset
- in_valid  in  1  in_data holds a valid window
- in_data  in  N*N*BitSize  window, element j (signed) at [j*BitSize +: BitSize]; element 0 top-left, row-major
- in_ready  out  1  FIFO can accept a window this cycle
- out_valid  out  1  out_data holds a valid result group
- out_ready  in  1  downstream accepts the result group
- out_data  out  ProcessingElements×BitSize  lane p = result of kernel g*ProcessingElements+p
- out_group  out  $clog2(Groups) (min 1)  group index g of the current output
- out_last  out  1  current output is the final group (g = Groups−1) of its window

## Operation
- Input transfer: occurs when in_valid && in_ready; the window is written to the FIFO tail.
- in_ready = (fifo_count < Depth) && res_n. A push while full is not possible. Push and pop in the same cycle are allowed, and the count is unchanged.
- Group counter g (0..Groups−1) selects the kernel group for the FIFO head.
- Output register load: fires when FIFO is non-empty && (!out_valid || out_ready).
  - out_data receives the results for head window and group g.
  - out_group receives g; out_last receives (g == Groups−1).
  - out_valid is set to 1.
  - If g == Groups−1, the head is popped and g returns to 0. Otherwise g increments.
- If out_valid && out_ready and the FIFO is empty, out_valid clears.
- While out_valid && !out_ready, out_data, out_group and out_last are held stable.
- Arithmetic per lane:
  - Products: pixel × weight, width BitSize+KernelBitSize.
  - Sum width: BitSize+KernelBitSize+$clog2(N*N), no overflow.
  - r = sum >>> OutShift.
  - If Relu and r < 0, then r = 0.
  - Saturate r to [−2^(BitSize−1), 2^(BitSize−1)−1].
- Reset (res_n low at a clock edge), including mid-window:
  - FIFO is flushed and g = 0.
  - out_valid = 0, out_data = 0, out_group = 0, out_last = 0.
  - The partially emitted window is discarded.

## Timing
- Latency: a window accepted at edge t (FIFO empty, output free) produces group 0 with out_valid high after edge t+1. Group g appears no earlier than after edge t+1+g.
- Throughput: Groups cycles per window with out_ready held high. A continuous input stream is sustained when Groups = 1.
- Window order and group order are strictly preserved. There are no bubbles between groups while the FIFO is non-empty and out_ready is high.
- Full FIFO: in_ready is low until the edge at which the last group of the head window is accepted. It rises in the following cycle.
- During reset cycles in_ready = 0. In the first cycle after reset deasserts, in_ready = 1 and out_valid = 0.

## Test plan
Common configuration for all scenarios: N=3, BitSize=8, KernelBitSize=2, ProcessingElements=2, NumberOfK=4, Depth=4. Kernels: k0 all +1, k1 all −1, k2 centre +1 with the rest 0, k3 all +1.

- Basic: one window of all 10s with out_ready=1 gives two outputs on consecutive cycles.
  - First: {90, −90}, group 0, last=0.
  - Second: {10, 90}, group 1, last=1.
- Saturation and ReLU: a window of all 100s gives {127, −128}, {100, 127}. With Relu=1, the same window gives {127, 0}, {100, 127}. With OutShift=2 and a window of all 10s, the first output is {22, −23}.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises. out_data, out_group and out_last must stay constant. 4 windows are accepted, then in_ready=0. After release, all 8 groups emerge in order.
- Full FIFO simultaneous push/pop: with the FIFO full, the final group is accepted while in_valid=1. That new window is not accepted on that edge. It is accepted on the next edge, and the count returns to 4.
- Reset mid-window: assert res_n=0 for one cycle right after group 0 of a window is accepted. Required response: out_valid=0, out_data=0, in_ready=0 during reset. After reset, in_ready=1, no stale group 1 appears, and the next window starts at group 0.
- Binary kernels (KernelBitSize=1, k0 all bits 1, k1 all bits 0) with a window of all 5s gives {45, −45}.
